// File: rtl/io_bus_bridge.sv
// io_bus_bridge: memory-mapped I/O bridge between proc and memory/peripherals.
// ADDR[15:12] selects MEM, LED, TIMER or SW. All reads return with one cycle of
// latency, matching the synchronous inst_mem.
// Build option: define IO_TIMER_EN to include the interval timer; without it the
// timer region reads 0, ignores writes, and tmr_irq is tied low.
module io_bus_bridge #(
  parameter int unsigned LED_W      = 9,
  parameter int unsigned SW_W       = 9,
  parameter int unsigned DEB_CYCLES = 4,
  parameter logic [3:0]  MEM_RGN    = 4'h0,
  parameter logic [3:0]  LED_RGN    = 4'h1,
  parameter logic [3:0]  TMR_RGN    = 4'h2,
  parameter logic [3:0]  SW_RGN     = 4'h3
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       DOUT,
  input  logic              W,
  input  logic [15:0]       mem_q,
  output logic              mem_wren,
  output logic [15:0]       DIN,
  input  logic [SW_W-1:0]   SW,
  output logic [LED_W-1:0]  LEDR,
  output logic              tmr_irq
);

  localparam int unsigned    CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [3:0]       rgn;
  logic [3:0]       rgn_q;
  logic [15:0]      rdata_d, rdata_q;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  s1_q, s2_q, sw_q, sw_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [15:0]      tmr_rdata;
  logic             unused_bits;

  assign rgn         = ADDR[15:12];
  assign mem_wren    = W && (rgn == MEM_RGN);
  assign LEDR        = led_q;
  assign DIN         = (rgn_q == MEM_RGN) ? mem_q : rdata_q;
  // Address bits inside a region are only partly decoded.
  assign unused_bits = ^{ADDR[11:0], DOUT};

  // Switch debounce: restart whenever the value entering s2 differs from s2.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    sw_d      = sw_q;
    if (s1_q != s2_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == CNT_MAX) begin
      sw_d = s2_q;
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
  end

  // I/O read mux; memory data bypasses it at the output.
  always_comb begin
    rdata_d = 16'd0;
    case (rgn)
      LED_RGN: rdata_d = 16'(led_q);
      SW_RGN:  rdata_d = 16'(sw_q);
      TMR_RGN: rdata_d = tmr_rdata;
      default: rdata_d = 16'd0;
    endcase
  end

  // Read pipeline, LED register, synchroniser and debounced switch register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rgn_q     <= MEM_RGN;
      rdata_q   <= 16'd0;
      led_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      sw_q      <= '0;
      deb_cnt_q <= '0;
    end else begin
      rgn_q     <= rgn;
      rdata_q   <= rdata_d;
      if (W && (rgn == LED_RGN)) led_q <= DOUT[LED_W-1:0];
      s1_q      <= SW;
      s2_q      <= s1_q;
      sw_q      <= sw_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

`ifdef IO_TIMER_EN
  logic [15:0] load_q, load_d, count_q, count_d;
  logic        en_q, en_d, auto_q, auto_d, exp_q, exp_d;
  logic        tmr_we, expire;

  assign tmr_we  = W && (rgn == TMR_RGN);
  assign expire  = en_q && (count_q == 16'd0);
  assign tmr_irq = exp_q;

  // Timer next state: hardware countdown first, then software writes override.
  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    en_d    = en_q;
    auto_d  = auto_q;
    exp_d   = exp_q;
    if (en_q) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (auto_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end
    if (tmr_we) begin
      case (ADDR[1:0])
        2'd0: begin
          load_d  = DOUT;
          count_d = DOUT;
        end
        2'd1: begin
          en_d   = DOUT[0];
          auto_d = DOUT[1];
        end
        2'd3: if (DOUT[0]) exp_d = 1'b0;
        default: ;
      endcase
    end
    // Expiry beats a simultaneous W1C.
    if (expire) exp_d = 1'b1;
  end

  // Timer register read mux.
  always_comb begin
    tmr_rdata = 16'd0;
    case (ADDR[1:0])
      2'd0: tmr_rdata = load_q;
      2'd1: tmr_rdata = {14'd0, auto_q, en_q};
      2'd2: tmr_rdata = count_q;
      2'd3: tmr_rdata = {15'd0, exp_q};
      default: tmr_rdata = 16'd0;
    endcase
  end

  // Timer state registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      load_q  <= 16'd0;
      count_q <= 16'd0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      exp_q   <= exp_d;
    end
  end
`else
  assign tmr_rdata = 16'd0;
  assign tmr_irq   = 1'b0;
`endif

endmodule
